// File: rtl/instruction_fetch_unit.sv
// Fetch controller between the PC and decode: issues an imem read, waits MEM_LATENCY cycles, captures, pulses pc_up.
// One word per MEM_LATENCY+2 cycles; holds instr_valid with no reads or PC pulses while instr_ready is low.
module instruction_fetch_unit #(
  parameter int          INSTR_W     = 16,
  parameter int          MEM_ADDR_W  = 8,
  parameter int          MEM_LATENCY = 1,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  start,
  input  logic [15:0]           pc_address,
  output logic                  pc_clear,
  output logic                  pc_up,
  output logic                  imem_rd,
  output logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic [INSTR_W-1:0]    imem_rdata,
  output logic [INSTR_W-1:0]    instr,
  output logic [15:0]           instr_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic                  halted
);

  typedef enum logic [2:0] {IDLE, PCCLR, ISSUE, WAIT, HOLD, HALTED} state_t;

  state_t     state;
  logic [2:0] lat_cnt;
  logic       rdata_is_halt;
  logic       held_is_halt;

  assign imem_addr     = pc_address[MEM_ADDR_W+1:2];
  assign rdata_is_halt = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);
  assign held_is_halt  = (instr[INSTR_W-1 -: 4] == HALT_OPCODE);

  // pc_up must follow the opcode arriving this cycle, so it cannot be a flop
  assign pc_up = (state == WAIT) && (lat_cnt == 3'd1) && !rdata_is_halt;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      pc_clear    <= 1'b0;
      imem_rd     <= 1'b0;
      instr       <= '0;
      instr_addr  <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else begin
      pc_clear <= 1'b0;
      imem_rd  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= PCCLR;
            pc_clear <= 1'b1;
          end
        end
        PCCLR: begin
          state   <= ISSUE;
          imem_rd <= 1'b1;
        end
        ISSUE: begin
          instr_addr <= pc_address;
          lat_cnt    <= 3'(MEM_LATENCY);
          state      <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (held_is_halt) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state   <= ISSUE;
              imem_rd <= 1'b1;
            end
          end
        end
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench: one fetch unit with MEM_LATENCY=1 and one with MEM_LATENCY=3, each with a PC and memory model.
module tb_instruction_fetch_unit;

  logic        clock = 1'b0;
  logic        clear_n1, clear_n3, start, instr_ready, sel3;
  logic        pc_clear1, pc_up1, imem_rd1, instr_valid1, halted1;
  logic        pc_clear3, pc_up3, imem_rd3, instr_valid3, halted3;
  logic [7:0]  imem_addr1, imem_addr3;
  logic [15:0] imem_rdata1, imem_rdata3, instr1, instr3, instr_addr1, instr_addr3;
  logic [15:0] pc1, pc3;
  logic [15:0] mem1 [256];
  logic [15:0] mem3 [256];
  logic        m1_vld;
  logic [15:0] m1_dat;
  logic [2:0]  m3_vld;
  logic [15:0] m3_dat [3];

  logic        o_pc_clear, o_pc_up, o_imem_rd, o_instr_valid, o_halted;
  logic [7:0]  o_imem_addr;
  logic [15:0] o_instr, o_instr_addr, o_pc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  instruction_fetch_unit #(.MEM_LATENCY(1)) u1 (
    .clock(clock), .clear_n(clear_n1), .start(start), .pc_address(pc1),
    .pc_clear(pc_clear1), .pc_up(pc_up1), .imem_rd(imem_rd1), .imem_addr(imem_addr1),
    .imem_rdata(imem_rdata1), .instr(instr1), .instr_addr(instr_addr1),
    .instr_valid(instr_valid1), .instr_ready(instr_ready), .halted(halted1));

  instruction_fetch_unit #(.MEM_LATENCY(3)) u3 (
    .clock(clock), .clear_n(clear_n3), .start(start), .pc_address(pc3),
    .pc_clear(pc_clear3), .pc_up(pc_up3), .imem_rd(imem_rd3), .imem_addr(imem_addr3),
    .imem_rdata(imem_rdata3), .instr(instr3), .instr_addr(instr_addr3),
    .instr_valid(instr_valid3), .instr_ready(instr_ready), .halted(halted3));

  // Program counters driven by the fetch unit's pulses; reset value is non-zero so pc_clear is visible
  always_ff @(posedge clock or negedge clear_n1)
    if (!clear_n1)      pc1 <= 16'h0040;
    else if (pc_clear1) pc1 <= 16'h0000;
    else if (pc_up1)    pc1 <= pc1 + 16'd4;

  always_ff @(posedge clock or negedge clear_n3)
    if (!clear_n3)      pc3 <= 16'h0040;
    else if (pc_clear3) pc3 <= 16'h0000;
    else if (pc_up3)    pc3 <= pc3 + 16'd4;

  // Memories: data valid exactly LATENCY cycles after imem_rd, garbage otherwise; not reset by clear_n
  always_ff @(posedge clock) begin
    m1_vld <= imem_rd1;
    m1_dat <= mem1[imem_addr1];
    m3_vld <= {m3_vld[1:0], imem_rd3};
    m3_dat[0] <= mem3[imem_addr3];
    m3_dat[1] <= m3_dat[0];
    m3_dat[2] <= m3_dat[1];
  end
  assign imem_rdata1 = m1_vld    ? m1_dat    : 16'hDEAD;
  assign imem_rdata3 = m3_vld[2] ? m3_dat[2] : 16'hF0AD;

  always_comb begin
    o_pc_clear    = sel3 ? pc_clear3    : pc_clear1;
    o_pc_up       = sel3 ? pc_up3       : pc_up1;
    o_imem_rd     = sel3 ? imem_rd3     : imem_rd1;
    o_imem_addr   = sel3 ? imem_addr3   : imem_addr1;
    o_instr       = sel3 ? instr3       : instr1;
    o_instr_addr  = sel3 ? instr_addr3  : instr_addr1;
    o_instr_valid = sel3 ? instr_valid3 : instr_valid1;
    o_halted      = sel3 ? halted3      : halted1;
    o_pc          = sel3 ? pc3          : pc1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Entered in the ISSUE cycle, returns in the first HOLD cycle
  task automatic fetch(input int lat, input logic [15:0] word, input logic [15:0] addr, input bit halt);
    logic [15:0] a;
    a = addr;
    chk("issue_rd", 32'(o_imem_rd), 32'd1);
    chk("issue_addr", 32'(o_imem_addr), 32'(a[9:2]));
    chk("issue_valid", 32'(o_instr_valid), 32'd0);
    for (int i = 1; i <= lat; i++) begin
      tick();
      chk("wait_rd", 32'(o_imem_rd), 32'd0);
      chk("wait_pc_clear", 32'(o_pc_clear), 32'd0);
      chk("wait_pc_up", 32'(o_pc_up), 32'((i == lat) && !halt));
    end
    tick();
    chk("hold_valid", 32'(o_instr_valid), 32'd1);
    chk("hold_instr", 32'(o_instr), 32'(word));
    chk("hold_addr", 32'(o_instr_addr), 32'(addr));
    chk("hold_pc_up", 32'(o_pc_up), 32'd0);
    chk("hold_rd", 32'(o_imem_rd), 32'd0);
  endtask

  initial begin
    clear_n1 = 1'b1; clear_n3 = 1'b1; start = 1'b0; instr_ready = 1'b1; sel3 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = 16'h0BAD;
      mem3[i] = 16'h0BAD;
    end
    mem1[0] = 16'h1111; mem1[1] = 16'h2222; mem1[2] = 16'h3333; mem1[3] = 16'hF000;
    mem3[0] = 16'hA5A5; mem3[1] = 16'h5A5A; mem3[2] = 16'h7777;
    #2;
    clear_n1 = 1'b0; clear_n3 = 1'b0;
    tick(); tick();

    // Reset values
    chk("rst_pc_clear", 32'(pc_clear1), 32'd0);
    chk("rst_pc_up", 32'(pc_up1), 32'd0);
    chk("rst_imem_rd", 32'(imem_rd1), 32'd0);
    chk("rst_instr", 32'(instr1), 32'd0);
    chk("rst_instr_addr", 32'(instr_addr1), 32'd0);
    chk("rst_valid", 32'(instr_valid1), 32'd0);
    chk("rst_halted", 32'(halted1), 32'd0);
    chk("rst_imem_addr", 32'(imem_addr1), 32'h10);

    // Start: pc_clear one cycle later, then first read at address 0
    clear_n1 = 1'b1;
    tick();
    chk("idle_pc_clear", 32'(pc_clear1), 32'd0);
    start = 1'b1;
    tick();
    chk("start_pc_clear", 32'(pc_clear1), 32'd1);
    chk("start_rd", 32'(imem_rd1), 32'd0);
    start = 1'b0;
    tick();
    fetch(1, 16'h1111, 16'd0, 1'b0);
    tick(); fetch(1, 16'h2222, 16'd4, 1'b0);
    tick(); fetch(1, 16'h3333, 16'd8, 1'b0);
    tick(); fetch(1, 16'hF000, 16'd12, 1'b1);
    tick();
    chk("halt_halted", 32'(halted1), 32'd1);
    chk("halt_valid", 32'(instr_valid1), 32'd0);
    chk("halt_pc", 32'(pc1), 32'd12);
    start = 1'b1;
    repeat (4) begin
      tick();
      chk("halted_start_rd", 32'(imem_rd1), 32'd0);
      chk("halted_start_pc_clear", 32'(pc_clear1), 32'd0);
      chk("halted_stays", 32'(halted1), 32'd1);
    end
    start = 1'b0;

    // Backpressure on the second word, HALT at address 8
    clear_n1 = 1'b0;
    mem1[2] = 16'hF000;
    tick();
    clear_n1 = 1'b1;
    start = 1'b1;
    tick();
    chk("b_start_pc_clear", 32'(pc_clear1), 32'd1);
    start = 1'b0;
    tick();
    fetch(1, 16'h1111, 16'd0, 1'b0);
    tick();
    instr_ready = 1'b0;
    fetch(1, 16'h2222, 16'd4, 1'b0);
    repeat (4) begin
      tick();
      chk("stall_valid", 32'(instr_valid1), 32'd1);
      chk("stall_instr", 32'(instr1), 32'h2222);
      chk("stall_rd", 32'(imem_rd1), 32'd0);
      chk("stall_pc_up", 32'(pc_up1), 32'd0);
      chk("stall_pc", 32'(pc1), 32'd8);
    end
    instr_ready = 1'b1;
    tick();
    fetch(1, 16'hF000, 16'd8, 1'b1);
    tick();
    chk("b_halted", 32'(halted1), 32'd1);
    chk("b_halt_valid", 32'(instr_valid1), 32'd0);
    chk("b_halt_pc", 32'(pc1), 32'd8);

    // MEM_LATENCY=3: period of 5, garbage before the valid cycle is never captured
    clear_n1 = 1'b0;
    sel3 = 1'b1;
    clear_n3 = 1'b1;
    tick();
    start = 1'b1;
    tick();
    chk("l3_pc_clear", 32'(pc_clear3), 32'd1);
    start = 1'b0;
    tick();
    fetch(3, 16'hA5A5, 16'd0, 1'b0);
    tick(); fetch(3, 16'h5A5A, 16'd4, 1'b0);
    tick();
    chk("l3_issue3_rd", 32'(imem_rd3), 32'd1);
    tick();

    // Reset in a WAIT cycle; the read data that arrives later must be ignored
    clear_n3 = 1'b0;
    #1;
    chk("mid_rst_rd", 32'(imem_rd3), 32'd0);
    chk("mid_rst_pc_up", 32'(pc_up3), 32'd0);
    chk("mid_rst_valid", 32'(instr_valid3), 32'd0);
    chk("mid_rst_instr", 32'(instr3), 32'd0);
    chk("mid_rst_addr", 32'(instr_addr3), 32'd0);
    tick();
    clear_n3 = 1'b1;
    repeat (4) begin
      tick();
      chk("late_pc_up", 32'(pc_up3), 32'd0);
      chk("late_valid", 32'(instr_valid3), 32'd0);
      chk("late_instr", 32'(instr3), 32'd0);
      chk("late_rd", 32'(imem_rd3), 32'd0);
    end
    start = 1'b1;
    tick();
    chk("restart_pc_clear", 32'(pc_clear3), 32'd1);
    start = 1'b0;
    tick();
    fetch(3, 16'hA5A5, 16'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
